// File: rtl/ibex_pkg.sv
// Shared types for the custom-instruction writeback path.
// Holds the buffered entry layout and the default buffer depth.
package ibex_pkg;

   localparam int unsigned CustomWbDepth = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } custom_wb_entry_t;

endpackage

// File: rtl/ibex_custom_wb_fifo.sv
// Generic writeback FIFO: storage, pointers, count and valid bits.
// Entries and valid bits are exported so the owner can scan for hazards.
module ibex_custom_wb_fifo
   import ibex_pkg::*;
#(
   parameter  int unsigned Depth = CustomWbDepth,
   localparam int unsigned PtrW  = $clog2(Depth),
   localparam int unsigned CntW  = PtrW + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  custom_wb_entry_t push_entry_i,
   input  logic             pop_i,
   output custom_wb_entry_t head_o,
   output custom_wb_entry_t entries_o [Depth],
   output logic [Depth-1:0] valid_o,
   output logic [CntW-1:0]  count_o
);

   custom_wb_entry_t mem_q [Depth];
   logic [PtrW-1:0]  wptr_q;
   logic [PtrW-1:0]  rptr_q;
   logic [CntW-1:0]  count_q;
   logic [Depth-1:0] valid_q;

   // Count is kept apart from the pointers so full and empty never alias.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         if (push_i) begin
            valid_q[wptr_q] <= 1'b1;
            wptr_q          <= wptr_q + PtrW'(1);
         end
         if (pop_i) begin
            valid_q[rptr_q] <= 1'b0;
            rptr_q          <= rptr_q + PtrW'(1);
         end
         unique case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !rst_i && !flush_i) begin
         mem_q[wptr_q] <= push_entry_i;
      end
   end

   assign head_o    = mem_q[rptr_q];
   assign entries_o = mem_q;
   assign valid_o   = valid_q;
   assign count_o   = count_q;

endmodule

// File: rtl/ibex_custom_wb_buffer.sv
// Custom-unit result buffer draining into free RF write-port cycles.
// Define IBEX_CUSTOM_WB_BYPASS_EN for same-cycle writeback when empty.
module ibex_custom_wb_buffer
   import ibex_pkg::*;
#(
   parameter  int unsigned Depth     = CustomWbDepth,
   parameter  int unsigned DataWidth = 32,
   localparam int unsigned CntW      = $clog2(Depth) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 custom_valid_i,
   input  logic [4:0]           custom_rd_addr_i,
   input  logic [DataWidth-1:0] custom_result_i,
   output logic                 custom_ready_o,
   input  logic                 flush_i,
   input  logic                 core_rf_we_i,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   input  logic [4:0]           rs1_addr_i,
   input  logic [4:0]           rs2_addr_i,
   output logic                 raw_hazard_o,
   output logic [CntW-1:0]      count_o,
   output logic                 busy_o
);

   custom_wb_entry_t push_entry;
   custom_wb_entry_t head;
   custom_wb_entry_t entries [Depth];
   logic [Depth-1:0] valid;
   logic [CntW-1:0]  count;
   logic             busy;
   logic             hs;
   logic             bypass;
   logic             push;
   logic             pop;

   assign busy           = (count != '0);
   assign custom_ready_o = (count < CntW'(Depth)) && !flush_i;
   assign hs             = custom_valid_i && custom_ready_o;

`ifdef IBEX_CUSTOM_WB_BYPASS_EN
   assign bypass = hs && (custom_rd_addr_i != 5'd0)
                   && !busy && !core_rf_we_i;
`else
   assign bypass = 1'b0;
`endif

   // Writes to x0 complete the handshake but are dropped here.
   assign push = hs && (custom_rd_addr_i != 5'd0) && !bypass;
   assign pop  = busy && !core_rf_we_i && !flush_i;

   assign push_entry.rd   = custom_rd_addr_i;
   assign push_entry.data = 32'(custom_result_i);

   ibex_custom_wb_fifo #(
      .Depth (Depth)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .head_o       (head),
      .entries_o    (entries),
      .valid_o      (valid),
      .count_o      (count)
   );

   always_comb begin
      rf_we_o    = pop || bypass;
      rf_waddr_o = 5'd0;
      rf_wdata_o = '0;
      if (bypass) begin
         rf_waddr_o = custom_rd_addr_i;
         rf_wdata_o = custom_result_i;
      end else if (busy) begin
         rf_waddr_o = head.rd;
         rf_wdata_o = DataWidth'(head.data);
      end
   end

   always_comb begin
      raw_hazard_o = 1'b0;
      for (int i = 0; i < Depth; i++) begin
         if (valid[i] &&
             (((rs1_addr_i != 5'd0) && (entries[i].rd == rs1_addr_i)) ||
              ((rs2_addr_i != 5'd0) && (entries[i].rd == rs2_addr_i)))) begin
            raw_hazard_o = 1'b1;
         end
      end
   end

   assign count_o = count;
   assign busy_o  = busy;

   // A stalled producer must hold its payload until accepted.
   assert property (@(posedge clk_i) disable iff (rst_i)
      custom_valid_i && !custom_ready_o && !flush_i
      |=> $stable(custom_rd_addr_i) && $stable(custom_result_i));

endmodule

// File: tb/tb_ibex_custom_wb_buffer.sv
// Directed bench for ibex_custom_wb_buffer.
// Inputs change 1ns after posedge, outputs checked 1ns later.
module tb_ibex_custom_wb_buffer;

   logic        clk;
   logic        rst_i;
   logic        custom_valid_i;
   logic [4:0]  custom_rd_addr_i;
   logic [31:0] custom_result_i;
   logic        custom_ready_o;
   logic        flush_i;
   logic        core_rf_we_i;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic        raw_hazard_o;
   logic [2:0]  count_o;
   logic        busy_o;

   int total = 0;
   int bad   = 0;

   ibex_custom_wb_buffer #(
      .Depth     (4),
      .DataWidth (32)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .custom_valid_i   (custom_valid_i),
      .custom_rd_addr_i (custom_rd_addr_i),
      .custom_result_i  (custom_result_i),
      .custom_ready_o   (custom_ready_o),
      .flush_i          (flush_i),
      .core_rf_we_i     (core_rf_we_i),
      .rf_we_o          (rf_we_o),
      .rf_waddr_o       (rf_waddr_o),
      .rf_wdata_o       (rf_wdata_o),
      .rs1_addr_i       (rs1_addr_i),
      .rs2_addr_i       (rs2_addr_i),
      .raw_hazard_o     (raw_hazard_o),
      .count_o          (count_o),
      .busy_o           (busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_i            = 1'b1;
      custom_valid_i   = 1'b0;
      custom_rd_addr_i = 5'd0;
      custom_result_i  = 32'd0;
      flush_i          = 1'b0;
      core_rf_we_i     = 1'b0;
      rs1_addr_i       = 5'd0;
      rs2_addr_i       = 5'd0;
      tick();
      rst_i = 1'b0;
      #1;
      chk("rst_we", rf_we_o, 0);
      chk("rst_ready", custom_ready_o, 1);
      chk("rst_haz", raw_hazard_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_busy", busy_o, 0);

      // Single push, written back the following cycle
      custom_valid_i   = 1'b1;
      custom_rd_addr_i = 5'd5;
      custom_result_i  = 32'hDEADBEEF;
      #1;
      chk("t1_ready", custom_ready_o, 1);
`ifndef IBEX_CUSTOM_WB_BYPASS_EN
      chk("t1_we_same", rf_we_o, 0);
      tick();
      custom_valid_i = 1'b0;
      #1;
      chk("t1_we", rf_we_o, 1);
      chk("t1_waddr", rf_waddr_o, 5);
      chk("t1_wdata", rf_wdata_o, 32'hDEADBEEF);
      chk("t1_count", count_o, 1);
`else
      chk("t1_we_byp", rf_we_o, 1);
      chk("t1_waddr_byp", rf_waddr_o, 5);
      tick();
      custom_valid_i = 1'b0;
      #1;
`endif
      tick();
      #1;
      chk("t1_count0", count_o, 0);
      chk("t1_we0", rf_we_o, 0);
      chk("t1_waddr0", rf_waddr_o, 0);

      // Fill while starved, then drain in order
      core_rf_we_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         custom_valid_i   = 1'b1;
         custom_rd_addr_i = 5'(i);
         custom_result_i  = 32'h100 + 32'(i);
         tick();
      end
      custom_rd_addr_i = 5'd5;
      custom_result_i  = 32'h105;
      #1;
      chk("full_count", count_o, 4);
      chk("full_ready", custom_ready_o, 0);
      chk("full_busy", busy_o, 1);
      chk("full_we", rf_we_o, 0);
      chk("full_head", rf_waddr_o, 1);
      tick();
      #1;
      chk("starve_count", count_o, 4);
      core_rf_we_i = 1'b0;
      #1;
      chk("drain_we1", rf_we_o, 1);
      chk("drain_waddr1", rf_waddr_o, 1);
      chk("drain_wdata1", rf_wdata_o, 32'h101);
      chk("drain_ready_full", custom_ready_o, 0);
      for (int k = 2; k <= 5; k++) begin
         tick();
         if (k == 3) custom_valid_i = 1'b0;
         #1;
         chk("drain_we", rf_we_o, 1);
         chk("drain_waddr", rf_waddr_o, 32'(k));
         chk("drain_wdata", rf_wdata_o, 32'h100 + 32'(k));
         if (k == 2) chk("drain_ready", custom_ready_o, 1);
         if (k == 3) chk("drain_count3", count_o, 3);
      end
      tick();
      #1;
      chk("drain_empty", count_o, 0);
      chk("drain_we_end", rf_we_o, 0);

      // RAW hazard on two pending rd=7 entries
      core_rf_we_i     = 1'b1;
      custom_valid_i   = 1'b1;
      custom_rd_addr_i = 5'd7;
      custom_result_i  = 32'h70;
      tick();
      custom_result_i = 32'h71;
      tick();
      custom_valid_i = 1'b0;
      rs1_addr_i     = 5'd7;
      #1;
      chk("haz_rs1", raw_hazard_o, 1);
      rs1_addr_i = 5'd0;
      #1;
      chk("haz_zero", raw_hazard_o, 0);
      rs2_addr_i = 5'd7;
      #1;
      chk("haz_rs2", raw_hazard_o, 1);
      rs1_addr_i = 5'd3;
      rs2_addr_i = 5'd0;
      #1;
      chk("haz_other", raw_hazard_o, 0);
      rs1_addr_i   = 5'd7;
      core_rf_we_i = 1'b0;
      #1;
      chk("haz_head_wr", raw_hazard_o, 1);
      chk("haz_wdata0", rf_wdata_o, 32'h70);
      tick();
      #1;
      chk("haz_wdata1", rf_wdata_o, 32'h71);
      chk("haz_still", raw_hazard_o, 1);
      tick();
      #1;
      chk("haz_clear", raw_hazard_o, 0);
      rs1_addr_i = 5'd0;

      // x0 results are accepted and dropped
      custom_valid_i   = 1'b1;
      custom_rd_addr_i = 5'd0;
      custom_result_i  = 32'h1234;
      #1;
      chk("x0_ready", custom_ready_o, 1);
      chk("x0_we_same", rf_we_o, 0);
      tick();
      custom_valid_i = 1'b0;
      #1;
      chk("x0_count", count_o, 0);
      chk("x0_we", rf_we_o, 0);

      // Flush with a concurrent push
      core_rf_we_i = 1'b1;
      for (int i = 10; i <= 12; i++) begin
         custom_valid_i   = 1'b1;
         custom_rd_addr_i = 5'(i);
         custom_result_i  = 32'(i);
         tick();
      end
      custom_rd_addr_i = 5'd13;
      core_rf_we_i     = 1'b0;
      flush_i          = 1'b1;
      #1;
      chk("fl_ready", custom_ready_o, 0);
      chk("fl_we", rf_we_o, 0);
      chk("fl_count_pre", count_o, 3);
      tick();
      flush_i        = 1'b0;
      custom_valid_i = 1'b0;
      rs1_addr_i     = 5'd10;
      rs2_addr_i     = 5'd13;
      #1;
      chk("fl_count", count_o, 0);
      chk("fl_busy", busy_o, 0);
      chk("fl_haz", raw_hazard_o, 0);
      chk("fl_we_post", rf_we_o, 0);

      // Reset in the middle of a drain
      core_rf_we_i = 1'b1;
      for (int i = 14; i <= 15; i++) begin
         custom_valid_i   = 1'b1;
         custom_rd_addr_i = 5'(i);
         custom_result_i  = 32'(i);
         tick();
      end
      custom_valid_i = 1'b0;
      core_rf_we_i   = 1'b0;
      rs1_addr_i     = 5'd15;
      rs2_addr_i     = 5'd0;
      #1;
      chk("rd_we", rf_we_o, 1);
      chk("rd_waddr", rf_waddr_o, 14);
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      chk("mrst_count", count_o, 0);
      chk("mrst_we", rf_we_o, 0);
      chk("mrst_ready", custom_ready_o, 1);
      chk("mrst_haz", raw_hazard_o, 0);
      chk("mrst_waddr", rf_waddr_o, 0);
      rs1_addr_i = 5'd0;

      // Empty buffer, rd=9
      custom_valid_i   = 1'b1;
      custom_rd_addr_i = 5'd9;
      custom_result_i  = 32'h1;
      #1;
`ifdef IBEX_CUSTOM_WB_BYPASS_EN
      chk("byp_we", rf_we_o, 1);
      chk("byp_waddr", rf_waddr_o, 9);
      chk("byp_wdata", rf_wdata_o, 1);
      tick();
      custom_valid_i = 1'b0;
      #1;
      chk("byp_count", count_o, 0);
`else
      chk("nb_we_same", rf_we_o, 0);
      tick();
      custom_valid_i = 1'b0;
      #1;
      chk("nb_we", rf_we_o, 1);
      chk("nb_waddr", rf_waddr_o, 9);
      chk("nb_count", count_o, 1);
`endif
      tick();
      #1;
      chk("end_count", count_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ibex_custom_wb_buffer.md
Name: ibex_custom_wb_buffer

Overview:
- Sits directly downstream of the EX stage's custom (bloom) unit, between the custom result path and the register-file write port.
- Queues custom-instruction results (rd address plus 32-bit data) in a small FIFO.
- Drains entries to the register file only in cycles where the main pipeline is not writing.
- Reports RAW hazards on pending destinations so ID can stall dependent instructions.

Parameters:
- Depth, 4, number of FIFO entries (power of two, >= 2).
- DataWidth, 32, width of result data.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- custom_valid_i  in  1  custom unit presents a result this cycle.
- custom_rd_addr_i  in  5  destination register of the result.
- custom_result_i  in  DataWidth  result data (bloom match zero-extended, or data).
- custom_ready_o  out  1  buffer can accept a push this cycle.
- flush_i  in  1  discard all pending entries (exception/debug).
- core_rf_we_i  in  1  main pipeline owns the RF write port this cycle.
- rf_we_o  out  1  buffer writes the RF this cycle.
- rf_waddr_o  out  5  RF write address.
- rf_wdata_o  out  DataWidth  RF write data.
- rs1_addr_i  in  5  ID-stage source 1 address.
- rs2_addr_i  in  5  ID-stage source 2 address.
- raw_hazard_o  out  1  rs1/rs2 matches a pending entry.
- count_o  out  $clog2(Depth)+1  occupied entries.
- busy_o  out  1  count_o != 0.

Behaviour:
- Reset (rst_i high at a clock edge): read/write pointers and count go to 0, all entry valid bits clear. Consequently rf_we_o=0, custom_ready_o=1, raw_hazard_o=0, count_o=0, busy_o=0.
- Push handshake: a push occurs on custom_valid_i && custom_ready_o. custom_ready_o = (count < Depth) && !flush_i. It does not depend on a pop in the same cycle: when full, ready stays low even if a pop occurs.
- x0 filter: a handshake with custom_rd_addr_i==0 is accepted but not stored; count is unchanged.
- Pop: rf_we_o = busy && !core_rf_we_i && !flush_i, combinational from the head entry. rf_waddr_o/rf_wdata_o come from the head entry. When rf_we_o=0 they are held at the head value, or 0 if empty.
- Pop and push may occur in the same cycle; count is unchanged in that case.
- Ordering: strict FIFO. The same rd pushed twice is written twice, in push order.
- Latency: an entry pushed at edge N is earliest on rf_we_o in cycle N+1 (without the optional feature).
- Starvation: while core_rf_we_i is held high, no pop occurs and entries wait indefinitely. No timeout.
- Hazard: raw_hazard_o is high iff some valid entry's rd equals a nonzero rs1_addr_i or rs2_addr_i. The comparison is combinational. The head entry being written in the current cycle still counts as a hazard.
- Flush: at the next edge, pointers and count go to 0 and all valid bits clear. A push or pop in the flush cycle is suppressed (ready=0, rf_we_o=0). flush_i has priority over rst_i-free operation only; rst_i dominates everything.
- Pointer wrap: pointers are $clog2(Depth) bits and wrap naturally. count is tracked separately, so full/empty are unambiguous.
- Illegal: custom_valid_i while !custom_ready_o is a stall; the upstream unit holds its result. Assertion: the payload is stable while valid && !ready.

Optional Feature:
- Macro: IBEX_CUSTOM_WB_BYPASS_EN.
- Defined: when the buffer is empty, !core_rf_we_i, !flush_i, and a push handshake with rd!=0 occurs, the result is driven onto rf_we_o/rf_waddr_o/rf_wdata_o in the same cycle and is not stored. raw_hazard_o does not flag bypassed results.
- Undefined: every result is stored; minimum latency is 1 cycle.

Decomposition:
- Shared package (ibex_pkg): typedef custom_wb_entry_t {logic [4:0] rd; logic [31:0] data;} and localparam CustomWbDepth = 4.
- One sub-module: ibex_custom_wb_fifo (generic storage, pointers, count, valid bits), which exposes the entry array for hazard comparison.
- The top level holds the arbitration, x0 filter, hazard compare, and bypass.

Test Plan:
- Reset, then push rd=5 data=0xDEADBEEF with core_rf_we_i=0 -> next cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF; count returns to 0.
- Hold core_rf_we_i=1 and push 4 entries (rd=1..4) -> count_o=4, custom_ready_o=0. A 5th valid is held. Release -> writes rd 1,2,3,4 on consecutive cycles, then the 5th is accepted.
- Two entries pending with rd=7, rs1_addr_i=7 -> raw_hazard_o=1. rs1=0 and rs2=0 -> raw_hazard_o=0.
- Push rd=0 data=0x1234 -> accepted, count stays 0, no rf_we_o.
- Three entries pending, assert flush_i together with custom_valid_i -> no push, rf_we_o=0, count_o=0 next cycle. Assert rst_i mid-drain -> all outputs return to reset values next cycle.
- With IBEX_CUSTOM_WB_BYPASS_EN, empty buffer, push rd=9 data=0x1 -> rf_we_o=1 in the same cycle, count stays 0.
